// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order response queue, redirect flush.
// Optional misaligned-redirect trap is compiled in with `define FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_misaligned
);
  localparam int            PW    = $clog2(QDEPTH);
  localparam int            CW    = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] DEPTH = CW'(QDEPTH);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   q_data [QDEPTH];
  logic [31:0]   q_pc   [QDEPTH];

  logic [31:0]   redir_target;
  logic          redir_misaligned;
  logic          req_accept;
  logic          rsp_live;
  logic          push;
  logic          pop;
  logic [CW-1:0] in_flight;
  logic [CW-1:0] drop_on_redirect;
  logic [CW:0]   credit_used;

  // Fetch always proceeds from a word-aligned target; misalignment only raises the trap.
  assign redir_target = redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_misaligned = (redirect_pc[1:0] != 2'b00);
`else
  assign redir_misaligned = 1'b0;
  assign fetch_misaligned = 1'b0;
`endif

  // A slot popped this cycle is free before any new response can land, so it counts as credit.
  assign credit_used    = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};
  assign imem_req_valid = !reset && (state == RUN) && !redirect_valid &&
                          (drop_cnt == '0) && (credit_used < {1'b0, DEPTH});
  assign imem_addr      = fetch_pc;
  assign req_accept     = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding belong to requests abandoned by a reset.
  assign rsp_live = imem_rsp_valid && (drop_cnt == '0) && (outstanding != '0);
  assign push     = rsp_live && !redirect_valid;

  assign inst_valid = !reset && (count != '0);
  assign inst       = q_data[rd_ptr];
  assign inst_pc    = q_pc[rd_ptr];
  assign pop        = inst_valid && inst_ready;

  assign in_flight        = drop_cnt + outstanding;
  assign drop_on_redirect = (imem_rsp_valid && in_flight != '0) ? in_flight - CW'(1) : in_flight;

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fetch_misaligned <= 1'b0;
`endif
    end else begin
      case (state)
        BOOT:    state <= RUN;
        RUN:     if (redirect_valid && redir_misaligned) state <= HALT;
        HALT:    if (redirect_valid && !redir_misaligned) state <= RUN;
        default: state <= BOOT;
      endcase

      if (redirect_valid) begin
        fetch_pc    <= redir_target;
        rsp_pc      <= redir_target;
        outstanding <= '0;
        drop_cnt    <= drop_on_redirect;
        count       <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
        fetch_misaligned <= redir_misaligned && (state != BOOT);
`endif
      end else begin
        if (req_accept) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        outstanding <= outstanding + CW'(req_accept) - CW'(rsp_live);
        count       <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // NOTE: queue storage has no reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clock) begin
    if (push) begin
      q_data[wr_ptr] <= imem_rsp_data;
      q_pc[wr_ptr]   <= rsp_pc;
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(push && !pop && count == DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with optional response hold.
module tb_fetch_unit;
  localparam logic [31:0] KEY = 32'hDEAD_0000;

  logic        clock;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_misaligned;

  int          total = 0;
  int          bad   = 0;
  int          n_acc = 0;
  int          n_del = 0;
  logic        mem_hold = 1'b0;
  logic [31:0] pend [$];

  fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clock            (clock),
    .reset            (reset),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_addr        (imem_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .inst             (inst),
    .inst_pc          (inst_pc),
    .fetch_misaligned (fetch_misaligned)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory: records accepts at negedge, answers in order from the next cycle unless held.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (imem_req_valid && imem_req_ready) begin
          pend.push_back(imem_addr);
          n_acc++;
        end
        if (inst_valid && inst_ready) n_del++;
      end
      @(posedge clock);
      #2;
      if (!mem_hold && pend.size() != 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pend.pop_front() ^ KEY;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h required=%h", tag, obs, exp);
    end
  endtask

  task automatic to_neg();
    @(negedge clock);
  endtask

  task automatic to_post();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench at the start of the BOOT cycle with reset released.
  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;
    imem_req_ready = 1'b1;
    mem_hold       = 1'b0;
    repeat (3) to_post();
    n_acc = 0;
    n_del = 0;
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;
    imem_req_ready = 1'b1;
    to_post();
    to_post();
    to_neg();
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_misaligned", fetch_misaligned, 0);

    // Streaming from reset.
    do_reset();
    to_neg();  check("boot_req_valid", imem_req_valid, 0);
    to_post(); to_neg();
    check("c1_req_valid", imem_req_valid, 1);
    check("c1_addr", imem_addr, 32'h0);
    to_post(); to_neg();
    check("c2_inst_valid", inst_valid, 0);
    check("c2_addr", imem_addr, 32'h4);
    to_post(); to_neg();
    check("c3_inst_valid", inst_valid, 1);
    check("c3_inst_pc", inst_pc, 32'h0);
    check("c3_inst", inst, KEY);
    to_post(); to_neg(); check("c4_inst_pc", inst_pc, 32'h4);
    to_post(); to_neg(); check("c5_inst_pc", inst_pc, 32'h8);

    // Consumer stalled: queue fills at two entries, head stays put.
    do_reset();
    inst_ready = 1'b0;
    to_post(); to_post(); to_neg();
    check("fill_c2_inst_valid", inst_valid, 0);
    for (int i = 0; i < 8; i++) begin
      to_post(); to_neg();
      check("fill_inst_pc", inst_pc, 32'h0);
      check("fill_inst", inst, KEY);
    end
    to_post();
    check("fill_accepts", n_acc, 2);
    inst_ready = 1'b1;
    to_neg();  check("fill_release_pc", inst_pc, 32'h0);
    to_post(); to_neg(); check("fill_next_pc", inst_pc, 32'h4);

    // Address held while the memory is not ready.
    do_reset();
    imem_req_ready = 1'b0;
    to_post(); to_neg(); check("stall_addr_a", imem_addr, 32'h0);
    to_post(); to_neg();
    check("stall_addr_b", imem_addr, 32'h0);
    check("stall_valid", imem_req_valid, 1);
    to_post(); imem_req_ready = 1'b1;
    to_neg();  check("stall_accept_addr", imem_addr, 32'h0);
    to_post(); to_neg(); check("stall_next_addr", imem_addr, 32'h4);

    // Redirect with two responses outstanding.
    do_reset();
    mem_hold = 1'b1;
    to_post(); to_post(); to_post();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    to_neg();  check("rd_c3_req_valid", imem_req_valid, 0);
    to_post();
    redirect_valid = 1'b0;
    mem_hold       = 1'b0;
    to_neg();  check("rd_c4_req_valid", imem_req_valid, 0);
    check("rd_c4_inst_valid", inst_valid, 0);
    to_post(); to_neg();
    check("rd_c5_req_valid", imem_req_valid, 0);
    check("rd_c5_inst_valid", inst_valid, 0);
    to_post(); to_neg();
    check("rd_c6_req_valid", imem_req_valid, 1);
    check("rd_c6_addr", imem_addr, 32'h100);
    check("rd_c6_inst_valid", inst_valid, 0);
    to_post(); to_neg(); check("rd_c7_inst_valid", inst_valid, 0);
    to_post(); to_neg();
    check("rd_c8_inst_pc", inst_pc, 32'h100);
    check("rd_c8_inst", inst, 32'h100 ^ KEY);

    // Redirect coinciding with a handshake and a response.
    do_reset();
    to_post(); to_post(); to_post();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    to_neg();
    check("rh_hs_valid", inst_valid, 1);
    check("rh_hs_pc", inst_pc, 32'h0);
    to_post();
    redirect_valid = 1'b0;
    to_neg();
    check("rh_flushed", inst_valid, 0);
    check("rh_new_addr", imem_addr, 32'h40);
    to_post(); to_post(); to_neg();
    check("rh_first_pc", inst_pc, 32'h40);
    to_post();
    check("rh_handshakes", n_del, 2);

    // Fetch PC wraps past the top of the address space.
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    to_neg();  check("wr_boot_req", imem_req_valid, 0);
    to_post(); redirect_valid = 1'b0;
    to_neg();  check("wr_addr_top", imem_addr, 32'hFFFF_FFFC);
    to_post(); to_neg(); check("wr_addr_zero", imem_addr, 32'h0);
    to_post(); to_neg(); check("wr_pc_top", inst_pc, 32'hFFFF_FFFC);
    to_post(); to_neg(); check("wr_pc_zero", inst_pc, 32'h0);

    // Reset mid-operation with two responses still in flight.
    do_reset();
    mem_hold = 1'b1;
    to_post(); to_post(); to_post();
    reset = 1'b1;
    to_post();
    reset    = 1'b0;
    mem_hold = 1'b0;
    to_neg();  check("mr_boot_req", imem_req_valid, 0);
    check("mr_boot_inst_valid", inst_valid, 0);
    to_post(); to_neg();
    check("mr_addr", imem_addr, 32'h0);
    check("mr_c5_inst_valid", inst_valid, 0);
    to_post(); to_neg(); check("mr_c6_inst_valid", inst_valid, 0);
    to_post(); to_neg();
    check("mr_c7_inst_pc", inst_pc, 32'h0);
    check("mr_c7_inst", inst, KEY);
    to_post(); to_neg();
    check("mr_c8_inst_pc", inst_pc, 32'h4);
    check("mr_c8_inst", inst, 32'h4 ^ KEY);

    // Misaligned redirect.
    do_reset();
    to_post();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    to_neg();  check("ma_redirect_req", imem_req_valid, 0);
    to_post(); redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      to_neg();
      check("ma_halt_req", imem_req_valid, 0);
      check("ma_flag_set", fetch_misaligned, 1);
      to_post();
    end
    check("ma_no_accepts", n_acc, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    to_neg();  check("ma_flag_hold", fetch_misaligned, 1);
    to_post(); redirect_valid = 1'b0;
    to_neg();
    check("ma_flag_clear", fetch_misaligned, 0);
    check("ma_resume_addr", imem_addr, 32'h200);
    to_post(); to_post(); to_neg();
    check("ma_first_pc", inst_pc, 32'h200);
`else
    to_neg();
    check("ma_masked_addr", imem_addr, 32'h100);
    check("ma_flag_tied", fetch_misaligned, 0);
    to_post(); to_post(); to_neg();
    check("ma_first_pc", inst_pc, 32'h100);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: address of the first fetch after reset.
REQ-002 SHALL have parameter QDEPTH, default 2: instruction queue depth, power of two, 2..8.
REQ-003 SHALL have port clock  in  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-005 SHALL have port imem_req_valid  out  1: fetch request valid.
REQ-006 SHALL have port imem_req_ready  in  1: memory accepts the request this cycle.
REQ-007 SHALL have port imem_addr  out  32: fetch address, word aligned.
REQ-008 SHALL have port imem_rsp_valid  in  1: in-order response valid, never earlier than one cycle after its request is accepted.
REQ-009 SHALL have port imem_rsp_data  in  32: fetched instruction word.
REQ-010 SHALL have port redirect_valid  in  1: branch/jump redirect from downstream.
REQ-011 SHALL have port redirect_pc  in  32: redirect target.
REQ-012 SHALL have port inst_valid  out  1: instruction available to the control unit.
REQ-013 SHALL have port inst_ready  in  1: control unit consumes the instruction this cycle.
REQ-014 SHALL have port inst  out  32: instruction word, queue head.
REQ-015 SHALL have port inst_pc  out  32: PC of inst.
REQ-016 SHALL have port fetch_misaligned  out  1: misaligned redirect flag.

Function
REQ-017 SHALL use a 3-state FSM: BOOT (first cycle after reset; no request), RUN (fetching), HALT (misaligned redirect; no request).
REQ-018 SHALL transition BOOT->RUN unconditionally, RUN->HALT on a misaligned redirect, and HALT->RUN on an aligned redirect.
REQ-019 SHALL assert imem_req_valid in RUN only when outstanding + queue occupancy < QDEPTH and redirect_valid is low.
REQ-020 SHALL hold imem_addr stable while imem_req_valid is high and imem_req_ready is low.
REQ-021 SHALL, on an accepted request (req_valid & req_ready), increment fetch PC by 4 (mod 2^32, wrapping 32'hFFFF_FFFC->0) and the outstanding count by 1.
REQ-022 SHALL push each non-dropped response into the queue tagged with a response PC that starts at the fetch-start address and increments by 4 per pushed response.
REQ-023 SHALL present the queue head combinationally on inst/inst_pc, with inst_valid = queue not empty.
REQ-024 SHALL pop the queue on inst_valid & inst_ready, and allow a push and a pop in the same cycle.
REQ-025 SHALL give a latency of one cycle from response to inst_valid when the queue is empty.
REQ-026 SHALL hold inst and inst_pc stable while inst_valid is high and inst_ready is low.
REQ-027 SHALL, on redirect_valid: complete any same-cycle inst handshake, flush the queue, load fetch PC and response PC with redirect_pc, and move outstanding into a drop counter.
REQ-028 SHALL, on redirect_valid, also drop a response arriving in that same cycle.
REQ-029 SHALL discard responses while the drop counter is nonzero, decrementing it by 1 per discarded response.
REQ-030 SHALL issue no request until the drop counter reaches zero.
REQ-031 SHALL treat back-to-back redirects such that the last one wins.
REQ-032 SHALL never overflow the queue; a push to a full queue is unreachable by credit (REQ-019) and SHALL be flagged by an assertion.

Reset
REQ-033 SHALL, on reset high at a clock edge, set FSM=BOOT, fetch PC=response PC=RESET_PC, queue empty, outstanding=0, drop=0, and fetch_misaligned=0.
REQ-034 SHALL hold imem_req_valid=0 and inst_valid=0 during reset and in BOOT.
REQ-035 SHALL, on reset mid-operation, abandon in-flight requests, discard their later responses, and begin fetching from RESET_PC.

Configuration
REQ-036 SHALL compile the misalignment check in when macro FETCH_MISALIGN_CHECK_EN is defined: a redirect_pc with [1:0]!=0 enters HALT, sets fetch_misaligned (sticky until the next aligned redirect or reset), and sends no requests.
REQ-037 SHALL, without FETCH_MISALIGN_CHECK_EN, force redirect_pc[1:0] to 0, never reach HALT, and tie fetch_misaligned to 0.

Verification
REQ-038 SHALL cover: reset released, memory always ready, 1-cycle responses, inst_ready=1 -> first imem_addr 0x0 in the cycle after BOOT; inst_pc sequence 0x0,0x4,0x8 on consecutive cycles.
REQ-039 SHALL cover: inst_ready=0 for 10 cycles -> queue fills with QDEPTH=2; no more than 2 requests accepted; inst=word@0x0 stable throughout.
REQ-040 SHALL cover: redirect to 0x100 with 2 responses outstanding -> both discarded; next inst_pc=0x100; no stale word delivered.
REQ-041 SHALL cover: redirect in the same cycle as an inst handshake and a response -> handshake counted once; response dropped; queue empty next cycle.
REQ-042 SHALL cover: with FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> fetch_misaligned=1, zero requests; a later redirect to 0x200 clears the flag and the first inst_pc is 0x200.
REQ-043 SHALL cover: fetch PC at 0xFFFF_FFFC -> next imem_addr 0x0.
